sparc_ifu_irferr_ctl: RTL and testbench
=======================================

// Module: sparc_ifu_irferr_ctl
// PURPOSE
//  IFU-side responder for the EXU integer-register-file ECC interface.
//  - Consumes M-stage CE/UE reports and logs them per thread in error status registers (ESRs).
//  - Raises W-stage trap/log strobes.
//  - Drives error injection (inj_irferr/ecc_mask) and retires it on exu_ifu_inj_ack.
//  - Optionally throttles CE storms by forcing EXU to treat CEs as UEs.
// PARAMETERS
//  NTHR        4     hardware threads (ESR count); TIDW = log2(NTHR)
//  CE_THRESH   8     CE events per window that trigger throttle (macro only)
//  CE_WINDOW   1024  window length in cycles, power of 2 (macro only)
// PORTS
//  clk                  in   1     core clock
//  arst_l               in   1     reset, asynchronous, active low
//  exu_ifu_ecc_ce_m     in   1     correctable error, M stage
//  exu_ifu_ecc_ue_m     in   1     uncorrectable error, M stage
//  exu_ifu_err_reg_m    in   8     {gl/cwp[2:0], rs[4:0]} of logged register
//  exu_ifu_err_synd_m   in   8     ECC syndrome of logged register
//  ifu_tid_m            in   TIDW  thread of M-stage instruction
//  ifu_kill_w           in   1     W-stage instruction killed
//  exu_ifu_inj_ack      in   1     EXU performed one injected write
//  asi_wr_esr           in   1     write ESR of asi_tid (W1C)
//  asi_wr_inj           in   1     write injection register
//  asi_tid              in   TIDW  thread for ESR write/read
//  asi_wr_data          in   19    write data
//  ifu_exu_inj_irferr   out  1     inject request to EXU
//  ifu_exu_ecc_mask     out  8     check-bit flip mask
//  ifu_exu_disable_ce_e out  1     force CE->UE in EXU
//  irferr_esr_rd        out  19    ESR[asi_tid], combinational read
//  irferr_ce_trap_w     out  1     CE trap/replay strobe, W
//  irferr_ue_w          out  1     UE log strobe, W
// BEHAVIOUR
//  - Reset: all ESRs, injection register and counters 0; FSM IDLE; every output 0.
//  - Pipeline: ce, ue, reg, synd, tid flopped M->W (1 cycle).
//    ev_w = (ce_w|ue_w) & ~ifu_kill_w.
//    irferr_ue_w = ue_w & ~kill_w; irferr_ce_trap_w = ce_w & ~ue_w & ~kill_w (UE wins).
//  - ESR format: [18] ue, [17] ce, [16] meu, [15:8] reg, [7:0] synd. Update at end of W; readable next cycle.
//    ESR[tid_w] rules on ev_w:
//    - ESR already has ue|ce -> set meu.
//    - ue_w & ~esr.ue -> capture reg/synd, set ue (UE overwrites a logged CE).
//    - ce_w & esr empty -> capture reg/synd, set ce.
//    - Otherwise reg/synd are held.
//  - ASI ESR write: W1C on [18:16] only; [15:0] unaffected.
//    Same-cycle capture and clear on the same bit -> set wins.
//  - Injection register: [8] enable, [9] oneshot, [7:0] mask.
//    ifu_exu_ecc_mask = mask, held constant.
//  - Injection FSM (IDLE, ARMED, WAIT); inj_irferr = (state==ARMED):
//    - IDLE -> ARMED: enable=1.
//    - ARMED, continuous (oneshot=0): stay ARMED.
//    - ARMED, oneshot=1: -> WAIT next cycle.
//    - WAIT, ack -> IDLE, enable cleared.
//    - WAIT, no ack -> ARMED.
//    - ARMED, ack while continuous: no change.
//    - asi_wr_inj with enable=0 -> IDLE next cycle from any state.
//    - Ack in IDLE: ignored.
//    - asi_wr_inj with enable=1 while ARMED/WAIT: reload mask/mode, restart at ARMED.
// CONFIGURATION
//  IRFERR_CE_THROTTLE_EN defined:
//  - Window counter wraps modulo CE_WINDOW; CE counter counts irferr_ce_trap_w, saturates at CE_THRESH.
//  - CE counter cleared at wrap unless throttled.
//  - Counter reaching CE_THRESH sets sticky ifu_exu_disable_ce_e.
//  - Any asi_wr_esr with data[17]=1 clears throttle and both counters.
//  Undefined: ifu_exu_disable_ce_e tied 0; counters absent.
// STRUCTURE
//  - Shared package: ESR bit positions, injection-register field positions, FSM state encodings, TIDW.
//  - Sub-module sparc_ifu_irferr_injfsm: injection FSM + inj register.
//  - ESR array, M->W flops and throttle stay in top.
// TESTING
//  - CE tid1, reg 8'h2B, synd 8'h15 -> ce_trap_w=1 one cycle later; ESR1=19'h22B15.
//  - CE then UE on tid0 -> ESR0 ue=1, ce=1, meu=1, reg/synd from UE. Same with kill_w on UE -> ESR unchanged.
//  - W1C data 19'h70000 same cycle as new CE, tid2 -> ce=1 retained; meu/ue cleared.
//  - Oneshot, mask 8'h81:
//    - inj pattern 1,0,1,0 until ack in WAIT -> IDLE, enable=0.
//    - Continuous mode: inj held high across 3 acks.
//  - Macro on, CE_THRESH=8: 8 CEs in window -> disable_ce_e=1. ESR write data[17]=1 -> 0.
//  - arst_l low mid-ARMED with ESRs set -> all outputs 0 immediately, ESRs clear.

Source files
------------

// File: rtl/sparc_ifu_irferr_pkg.sv
// Shared definitions for the IFU integer-register-file ECC error controller.
// ESR layout, injection-register fields, injection FSM states, throttle sizing.
package sparc_ifu_irferr_pkg;

  localparam int NTHR = 4;
  localparam int TIDW = $clog2(NTHR);

  localparam int ESRW    = 19;
  localparam int ESR_UE  = 18;
  localparam int ESR_CE  = 17;
  localparam int ESR_MEU = 16;

  localparam int INJW   = 10;
  localparam int INJ_EN = 8;
  localparam int INJ_OS = 9;

  localparam int CE_THRESH = 8;
  localparam int CE_WINDOW = 1024;

  typedef enum logic [1:0] {
    INJ_IDLE  = 2'd0,
    INJ_ARMED = 2'd1,
    INJ_WAIT  = 2'd2
  } inj_state_e;

  typedef struct packed {
    logic       ue;
    logic       ce;
    logic       meu;
    logic [7:0] rg;
    logic [7:0] synd;
  } esr_t;

endpackage

// File: rtl/sparc_ifu_irferr_injfsm.sv
// Error-injection register and request FSM toward the EXU.
// Oneshot mode alternates ARMED/WAIT until the EXU acknowledges.
module sparc_ifu_irferr_injfsm
  import sparc_ifu_irferr_pkg::*;
(
  input  logic            clk,
  input  logic            arst_l,
  input  logic            asi_wr_inj,
  input  logic [INJW-1:0] wr_data,
  input  logic            inj_ack,
  output logic            inj_irferr,
  output logic [7:0]      ecc_mask
);

  inj_state_e      st;
  logic [INJW-1:0] inj_reg;

  assign ecc_mask = inj_reg[7:0];

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      st         <= INJ_IDLE;
      inj_reg    <= '0;
      inj_irferr <= 1'b0;
    end else if (asi_wr_inj) begin
      inj_reg    <= wr_data;
      st         <= wr_data[INJ_EN] ? INJ_ARMED : INJ_IDLE;
      inj_irferr <= wr_data[INJ_EN];
    end else begin
      unique case (st)
        INJ_ARMED: begin
          if (inj_reg[INJ_OS]) begin
            st         <= INJ_WAIT;
            inj_irferr <= 1'b0;
          end
        end
        INJ_WAIT: begin
          if (inj_ack) begin
            st              <= INJ_IDLE;
            inj_reg[INJ_EN] <= 1'b0;
          end else begin
            st         <= INJ_ARMED;
            inj_irferr <= 1'b1;
          end
        end
        default: begin
          st         <= INJ_IDLE;
          inj_irferr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sparc_ifu_irferr_ctl.sv
// IFU responder for EXU IRF ECC reports: per-thread ESRs, W strobes, injection.
// Define IRFERR_CE_THROTTLE_EN to add the CE-storm throttle (CE->UE forcing).
module sparc_ifu_irferr_ctl
  import sparc_ifu_irferr_pkg::*;
(
  input  logic            clk,
  input  logic            arst_l,
  input  logic            exu_ifu_ecc_ce_m,
  input  logic            exu_ifu_ecc_ue_m,
  input  logic [7:0]      exu_ifu_err_reg_m,
  input  logic [7:0]      exu_ifu_err_synd_m,
  input  logic [TIDW-1:0] ifu_tid_m,
  input  logic            ifu_kill_w,
  input  logic            exu_ifu_inj_ack,
  input  logic            asi_wr_esr,
  input  logic            asi_wr_inj,
  input  logic [TIDW-1:0] asi_tid,
  input  logic [ESRW-1:0] asi_wr_data,
  output logic            ifu_exu_inj_irferr,
  output logic [7:0]      ifu_exu_ecc_mask,
  output logic            ifu_exu_disable_ce_e,
  output logic [ESRW-1:0] irferr_esr_rd,
  output logic            irferr_ce_trap_w,
  output logic            irferr_ue_w
);

  logic            ce_w;
  logic            ue_w;
  logic [7:0]      reg_w;
  logic [7:0]      synd_w;
  logic [TIDW-1:0] tid_w;
  logic            ev_w;
  esr_t            esr_q [NTHR];
  logic            unused_bits;

  assign unused_bits = ^asi_wr_data[15:INJW];

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      ce_w   <= 1'b0;
      ue_w   <= 1'b0;
      reg_w  <= '0;
      synd_w <= '0;
      tid_w  <= '0;
    end else begin
      ce_w   <= exu_ifu_ecc_ce_m;
      ue_w   <= exu_ifu_ecc_ue_m;
      reg_w  <= exu_ifu_err_reg_m;
      synd_w <= exu_ifu_err_synd_m;
      tid_w  <= ifu_tid_m;
    end
  end

  assign ev_w             = (ce_w | ue_w) & ~ifu_kill_w;
  assign irferr_ue_w      = ue_w & ~ifu_kill_w;
  assign irferr_ce_trap_w = ce_w & ~ue_w & ~ifu_kill_w;

  for (genvar g = 0; g < NTHR; g++) begin : g_esr
    logic hit;
    logic wclr;
    logic cap_ue;
    logic cap_ce;

    assign hit    = ev_w & (tid_w == TIDW'(g));
    assign wclr   = asi_wr_esr & (asi_tid == TIDW'(g));
    assign cap_ue = hit & ue_w & ~esr_q[g].ue;
    assign cap_ce = hit & ce_w & ~esr_q[g].ue & ~esr_q[g].ce;

    // New capture beats a same-cycle W1C of the same bit
    always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
        esr_q[g] <= '0;
      end else begin
        esr_q[g].ue  <= cap_ue |
                        (esr_q[g].ue & ~(wclr & asi_wr_data[ESR_UE]));
        esr_q[g].ce  <= cap_ce |
                        (esr_q[g].ce & ~(wclr & asi_wr_data[ESR_CE]));
        esr_q[g].meu <= (hit & (esr_q[g].ue | esr_q[g].ce)) |
                        (esr_q[g].meu & ~(wclr & asi_wr_data[ESR_MEU]));
        if (cap_ue | cap_ce) begin
          esr_q[g].rg   <= reg_w;
          esr_q[g].synd <= synd_w;
        end
      end
    end
  end

  assign irferr_esr_rd = esr_q[asi_tid];

  sparc_ifu_irferr_injfsm u_injfsm (
    .clk        (clk),
    .arst_l     (arst_l),
    .asi_wr_inj (asi_wr_inj),
    .wr_data    (asi_wr_data[INJW-1:0]),
    .inj_ack    (exu_ifu_inj_ack),
    .inj_irferr (ifu_exu_inj_irferr),
    .ecc_mask   (ifu_exu_ecc_mask)
  );

`ifdef IRFERR_CE_THROTTLE_EN
  localparam int WINW = $clog2(CE_WINDOW);
  localparam int CNTW = $clog2(CE_THRESH + 1);

  logic [WINW-1:0] win_cnt;
  logic [CNTW-1:0] ce_cnt;
  logic [CNTW-1:0] ce_inc;
  logic            throttle;
  logic            thr_clr;

  assign thr_clr = asi_wr_esr & asi_wr_data[ESR_CE];
  assign ce_inc  = ce_cnt + CNTW'(irferr_ce_trap_w &
                   (ce_cnt != CNTW'(CE_THRESH)));

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      win_cnt  <= '0;
      ce_cnt   <= '0;
      throttle <= 1'b0;
    end else if (thr_clr) begin
      win_cnt  <= '0;
      ce_cnt   <= '0;
      throttle <= 1'b0;
    end else begin
      win_cnt  <= win_cnt + 1'b1;
      ce_cnt   <= (&win_cnt && !throttle) ? '0 : ce_inc;
      throttle <= throttle | (ce_inc == CNTW'(CE_THRESH));
    end
  end

  assign ifu_exu_disable_ce_e = throttle;
`else
  assign ifu_exu_disable_ce_e = 1'b0;
`endif

endmodule

// File: tb/tb_sparc_ifu_irferr_ctl.sv
// Directed-vector bench for sparc_ifu_irferr_ctl.
// Table of M-stage reports plus hand sequences for W1C, injection and reset.
module tb_sparc_ifu_irferr_ctl;

  logic        clk = 1'b0;
  logic        arst_l = 1'b0;
  logic        ce_m = 1'b0;
  logic        ue_m = 1'b0;
  logic [7:0]  reg_m = '0;
  logic [7:0]  synd_m = '0;
  logic [1:0]  tid_m = '0;
  logic        kill_w = 1'b0;
  logic        inj_ack = 1'b0;
  logic        wr_esr = 1'b0;
  logic        wr_inj = 1'b0;
  logic [1:0]  asi_tid = '0;
  logic [18:0] wr_data = '0;
  logic        inj;
  logic [7:0]  mask;
  logic        dis_ce;
  logic [18:0] esr_rd;
  logic        ce_trap;
  logic        ue_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sparc_ifu_irferr_ctl dut (
    .clk                  (clk),
    .arst_l               (arst_l),
    .exu_ifu_ecc_ce_m     (ce_m),
    .exu_ifu_ecc_ue_m     (ue_m),
    .exu_ifu_err_reg_m    (reg_m),
    .exu_ifu_err_synd_m   (synd_m),
    .ifu_tid_m            (tid_m),
    .ifu_kill_w           (kill_w),
    .exu_ifu_inj_ack      (inj_ack),
    .asi_wr_esr           (wr_esr),
    .asi_wr_inj           (wr_inj),
    .asi_tid              (asi_tid),
    .asi_wr_data          (wr_data),
    .ifu_exu_inj_irferr   (inj),
    .ifu_exu_ecc_mask     (mask),
    .ifu_exu_disable_ce_e (dis_ce),
    .irferr_esr_rd        (esr_rd),
    .irferr_ce_trap_w     (ce_trap),
    .irferr_ue_w          (ue_w)
  );

  typedef struct {
    logic        ce;
    logic        ue;
    logic [7:0]  rg;
    logic [7:0]  sy;
    logic [1:0]  tid;
    logic        kill;
    logic        x_trap;
    logic        x_ue;
    logic [18:0] x_esr;
  } vec_t;

  vec_t v [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_esr(input string nm, input logic [1:0] t,
                        input logic [18:0] exp);
    asi_tid = t;
    #1;
    chk(nm, 32'(esr_rd), 32'(exp));
  endtask

  task automatic wr_inj_reg(input logic [18:0] d);
    wr_inj  = 1'b1;
    wr_data = d;
    cyc();
    wr_inj  = 1'b0;
    wr_data = '0;
  endtask

  initial begin
    v[0] = '{1'b1, 1'b0, 8'h2B, 8'h15, 2'd1, 1'b0, 1'b1, 1'b0, 19'h22B15};
    v[1] = '{1'b1, 1'b0, 8'h11, 8'h22, 2'd0, 1'b0, 1'b1, 1'b0, 19'h21122};
    v[2] = '{1'b0, 1'b1, 8'h33, 8'h44, 2'd0, 1'b0, 1'b0, 1'b1, 19'h73344};
    v[3] = '{1'b1, 1'b0, 8'h12, 8'h34, 2'd3, 1'b0, 1'b1, 1'b0, 19'h21234};
    v[4] = '{1'b0, 1'b1, 8'h55, 8'h66, 2'd3, 1'b1, 1'b0, 1'b0, 19'h21234};
    v[5] = '{1'b1, 1'b0, 8'h77, 8'h88, 2'd1, 1'b0, 1'b1, 1'b0, 19'h32B15};
    v[6] = '{1'b0, 1'b1, 8'h99, 8'hAA, 2'd1, 1'b0, 1'b0, 1'b1, 19'h799AA};
    v[7] = '{1'b0, 1'b1, 8'hBB, 8'hCC, 2'd1, 1'b0, 1'b0, 1'b1, 19'h799AA};
    v[8] = '{1'b1, 1'b0, 8'hDD, 8'hEE, 2'd0, 1'b1, 1'b0, 1'b0, 19'h73344};

    #12;
    chk("rst_inj", 32'(inj), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_esr", 32'(esr_rd), 32'd0);
    chk("rst_strobes", 32'({ce_trap, ue_w, dis_ce}), 32'd0);
    arst_l = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) begin
      ce_m   = v[i].ce;
      ue_m   = v[i].ue;
      reg_m  = v[i].rg;
      synd_m = v[i].sy;
      tid_m  = v[i].tid;
      cyc();
      ce_m   = 1'b0;
      ue_m   = 1'b0;
      kill_w = v[i].kill;
      #1;
      chk($sformatf("v%0d_trap", i), 32'(ce_trap), 32'(v[i].x_trap));
      chk($sformatf("v%0d_ue", i), 32'(ue_w), 32'(v[i].x_ue));
      cyc();
      kill_w = 1'b0;
      rd_esr($sformatf("v%0d_esr", i), v[i].tid, v[i].x_esr);
    end

    // W1C of all flags on tid2 in the same cycle its CE is in W
    ce_m   = 1'b1;
    tid_m  = 2'd2;
    reg_m  = 8'hC3;
    synd_m = 8'h5A;
    cyc();
    ce_m    = 1'b0;
    wr_esr  = 1'b1;
    asi_tid = 2'd2;
    wr_data = 19'h70000;
    #1;
    chk("w1c_trap", 32'(ce_trap), 32'd1);
    cyc();
    wr_esr  = 1'b0;
    wr_data = '0;
    rd_esr("w1c_set_wins", 2'd2, 19'h2C35A);

    wr_esr  = 1'b1;
    asi_tid = 2'd0;
    wr_data = 19'h7FFFF;
    cyc();
    wr_esr  = 1'b0;
    wr_data = '0;
    rd_esr("w1c_tid0", 2'd0, 19'h03344);
    rd_esr("w1c_tid1_kept", 2'd1, 19'h799AA);

    // Oneshot injection, mask 81
    wr_inj_reg(19'h00381);
    chk("os_c1", 32'({inj, mask}), 32'h181);
    cyc();
    chk("os_c2", 32'(inj), 32'd0);
    cyc();
    chk("os_c3", 32'(inj), 32'd1);
    cyc();
    chk("os_c4", 32'(inj), 32'd0);
    inj_ack = 1'b1;
    cyc();
    inj_ack = 1'b0;
    chk("os_ack_idle", 32'({inj, mask}), 32'h081);
    cyc();
    chk("os_idle_hold", 32'(inj), 32'd0);
    inj_ack = 1'b1;
    cyc();
    inj_ack = 1'b0;
    cyc();
    chk("ack_in_idle", 32'(inj), 32'd0);

    // Continuous injection survives acks
    wr_inj_reg(19'h00181);
    for (int i = 0; i < 6; i++) begin
      inj_ack = i[0];
      chk($sformatf("cont_%0d", i), 32'(inj), 32'd1);
      cyc();
    end
    inj_ack = 1'b0;
    chk("cont_end", 32'(inj), 32'd1);
    wr_inj_reg(19'h00000);
    chk("disable_inj", 32'(inj), 32'd0);

    // Reload while ARMED in oneshot mode restarts at ARMED
    wr_inj_reg(19'h00342);
    cyc();
    chk("reload_wait", 32'(inj), 32'd0);
    wr_inj_reg(19'h00324);
    chk("reload_armed", 32'({inj, mask}), 32'h124);
    wr_inj_reg(19'h00000);

`ifdef IRFERR_CE_THROTTLE_EN
    wr_esr  = 1'b1;
    asi_tid = 2'd3;
    wr_data = 19'h20000;
    cyc();
    wr_esr  = 1'b0;
    wr_data = '0;
    tid_m   = 2'd3;
    for (int i = 0; i < 7; i++) begin
      ce_m = 1'b1;
      cyc();
    end
    ce_m = 1'b0;
    cyc();
    cyc();
    chk("thr_7ce", 32'(dis_ce), 32'd0);
    ce_m = 1'b1;
    cyc();
    ce_m = 1'b0;
    cyc();
    cyc();
    chk("thr_8ce", 32'(dis_ce), 32'd1);
    wr_esr  = 1'b1;
    wr_data = 19'h20000;
    cyc();
    wr_esr  = 1'b0;
    wr_data = '0;
    chk("thr_clear", 32'(dis_ce), 32'd0);
`else
    chk("no_throttle", 32'(dis_ce), 32'd0);
`endif

    // Async reset in the middle of an ARMED cycle
    wr_inj_reg(19'h001A5);
    chk("pre_rst_inj", 32'(inj), 32'd1);
    asi_tid = 2'd1;
    #2;
    arst_l = 1'b0;
    #1;
    chk("arst_inj", 32'({inj, mask}), 32'd0);
    chk("arst_esr", 32'(esr_rd), 32'd0);
    chk("arst_dis", 32'(dis_ce), 32'd0);
    cyc();
    arst_l = 1'b1;
    cyc();
    chk("post_rst_inj", 32'(inj), 32'd0);
    rd_esr("post_rst_esr0", 2'd0, 19'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
